// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: one op per valid/ready handshake; logic/arith/illegal ops take 1 cycle, shifts take 1+shamt cycles.
// Latency: result valid 1 cycle after accept (shamt+1 for shifts with shamt>0).
// Backpressure: in_ready only in IDLE; the result holds in DONE until out_ready, so back-to-back issue is every 2 cycles.
module alu_exec_unit #(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_control,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic [4:0]      rd_addr,
    input  logic            regwrite_in,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_addr_out,
    output logic            regwrite_out,
    output logic            illegal_op
);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SLL  = 4'b0011;
    localparam logic [3:0] OP_SUB  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_SLTU = 4'b0110;
    localparam logic [3:0] OP_XOR  = 4'b0111;
    localparam logic [3:0] OP_SLT  = 4'b1000;
    localparam logic [3:0] OP_SRA  = 4'b1001;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t               state, state_nxt;
    logic [SHAMT_W-1:0]   count;
    logic [3:0]           sh_op;
    logic [SHAMT_W-1:0]   shamt;
    logic [XLEN-1:0]      alu_res;
    logic [XLEN-1:0]      shift_step;
    logic                 is_shift;
    logic                 is_illegal;
    logic                 accept;
    logic                 start_shift;

    assign shamt       = op_b[SHAMT_W-1:0];
    assign accept      = in_valid && in_ready;
    assign start_shift = is_shift && (shamt != '0);

    // Shifts with shamt==0 fall through to op_a so they complete in one cycle.
    always_comb begin
        alu_res    = '0;
        is_shift   = 1'b0;
        is_illegal = 1'b0;
        case (alu_control)
            OP_AND:  alu_res = op_a & op_b;
            OP_OR:   alu_res = op_a | op_b;
            OP_ADD:  alu_res = op_a + op_b;
            OP_SUB:  alu_res = op_a - op_b;
            OP_XOR:  alu_res = op_a ^ op_b;
            OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
            OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            OP_SLL, OP_SRL, OP_SRA: begin
                alu_res  = op_a;
                is_shift = 1'b1;
            end
            default: is_illegal = 1'b1;
        endcase
    end

    always_comb begin
        case (sh_op)
            OP_SLL:  shift_step = {result[XLEN-2:0], 1'b0};
            OP_SRL:  shift_step = {1'b0, result[XLEN-1:1]};
            default: shift_step = {result[XLEN-1], result[XLEN-1:1]};
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = start_shift ? SHIFT : DONE;
            end
            SHIFT: begin
                if (count == SHAMT_W'(1)) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The result register doubles as the shift register while in SHIFT.
    always_ff @(posedge clk) begin
        if (rst) begin
            result       <= '0;
            rd_addr_out  <= '0;
            regwrite_out <= 1'b0;
            illegal_op   <= 1'b0;
            count        <= '0;
            sh_op        <= '0;
        end else if (accept) begin
            rd_addr_out  <= rd_addr;
            regwrite_out <= regwrite_in && !is_illegal;
            illegal_op   <= is_illegal;
            sh_op        <= alu_control;
            result       <= alu_res;
            if (start_shift) count <= shamt;
        end else if (state == SHIFT) begin
            result <= shift_step;
            count  <= count - SHAMT_W'(1);
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Randomized and directed bench for alu_exec_unit against an arithmetic reference model.
module tb_alu_exec_unit;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [3:0]      alu_control;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [4:0]      rd_addr;
    logic            regwrite_in;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic [4:0]      rd_addr_out;
    logic            regwrite_out;
    logic            illegal_op;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    alu_exec_unit #(.XLEN(XLEN)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .alu_control(alu_control), .op_a(op_a), .op_b(op_b),
        .rd_addr(rd_addr), .regwrite_in(regwrite_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .rd_addr_out(rd_addr_out),
        .regwrite_out(regwrite_out), .illegal_op(illegal_op)
    );

    function automatic logic [XLEN-1:0] ref_result(input logic [3:0] c, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        int unsigned sh;
        sh = b % XLEN;
        case (c)
            4'd0: return a & b;
            4'd1: return a | b;
            4'd2: return a + b;
            4'd3: return a << sh;
            4'd4: return a - b;
            4'd5: return a >> sh;
            4'd6: return (a < b) ? 1 : 0;
            4'd7: return a ^ b;
            4'd8: return ($signed(a) < $signed(b)) ? 1 : 0;
            4'd9: return $signed(a) >>> sh;
            default: return 0;
        endcase
    endfunction

    function automatic int ref_latency(input logic [3:0] c, input logic [XLEN-1:0] b);
        int sh;
        sh = int'(b % XLEN);
        if ((c == 4'd3 || c == 4'd5 || c == 4'd9) && sh != 0) return sh + 1;
        return 1;
    endfunction

    // Drives one request at the current point (just after an edge) and returns just after the accepting edge.
    task automatic start_op(input logic [3:0] c, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                            input logic [4:0] rd, input logic rw);
        alu_control = c; op_a = a; op_b = b; rd_addr = rd; regwrite_in = rw;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Edges after the accepting edge until out_valid; -1 on timeout.
    task automatic wait_result(output int lat);
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) lat = -1;
    endtask

    task automatic retire();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        alu_control = 4'd2; op_a = 32'h1234; op_b = 32'h1; rd_addr = 5'd7; regwrite_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({out_valid, in_ready, result, rd_addr_out, regwrite_out, illegal_op} !== {1'b0, 1'b1, 32'h0, 5'd0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset: got valid=%b rdy=%b res=%h rd=%0d rw=%b ill=%b required 0 1 0 0 0 0",
                     out_valid, in_ready, result, rd_addr_out, regwrite_out, illegal_op);
        end
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        @(posedge clk); #1;
    endtask

    logic [3:0]      dc [8] = '{4'd2, 4'd4, 4'd8, 4'd6, 4'd7, 4'd9, 4'd5, 4'd3};
    logic [XLEN-1:0] da [8] = '{32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hF0F0, 32'h80000000, 32'h80000000, 32'hDEADBEEF};
    logic [XLEN-1:0] db [8] = '{32'h1, 32'h1, 32'h1, 32'h1, 32'hFF00, 32'd31, 32'd31, 32'h0};
    logic [XLEN-1:0] dr [8] = '{32'h0, 32'hFFFFFFFF, 32'h1, 32'h0, 32'h0FF0, 32'hFFFFFFFF, 32'h1, 32'hDEADBEEF};
    int              dl [8] = '{1, 1, 1, 1, 1, 32, 32, 1};

    task automatic test_directed();
        int lat;
        for (int i = 0; i < 8; i++) begin
            start_op(dc[i], da[i], db[i], 5'(i + 1), 1'b1);
            wait_result(lat);
            vectors++;
            if (lat !== dl[i] || result !== dr[i]) begin
                miscompares++;
                $display("FAIL directed[%0d]: got res=%h lat=%0d required res=%h lat=%0d", i, result, lat, dr[i], dl[i]);
            end
            retire();
        end
    endtask

    task automatic test_illegal();
        int lat;
        start_op(4'hF, 32'hAAAA5555, 32'h1, 5'd9, 1'b1);
        wait_result(lat);
        vectors++;
        if ({lat == 1, illegal_op, regwrite_out, result, rd_addr_out} !== {1'b1, 1'b1, 1'b0, 32'h0, 5'd9}) begin
            miscompares++;
            $display("FAIL illegal: got lat=%0d ill=%b rw=%b res=%h rd=%0d required 1 1 0 0 9",
                     lat, illegal_op, regwrite_out, result, rd_addr_out);
        end
        retire();
    endtask

    task automatic test_random();
        int lat;
        logic [3:0] c;
        logic [XLEN-1:0] a, b, er;
        logic [4:0] rd;
        logic rw, eill;
        for (int i = 0; i < 60; i++) begin
            c = 4'($urandom_range(0, 15));
            a = $urandom; b = $urandom;
            if (i % 3 == 0) a = {a[XLEN-1], 31'h0} | (a & 32'hF);
            rd = 5'($urandom_range(0, 31)); rw = 1'($urandom_range(0, 1));
            er = ref_result(c, a, b);
            eill = (c > 4'd9);
            start_op(c, a, b, rd, rw);
            wait_result(lat);
            vectors++;
            if (lat !== ref_latency(c, b) || result !== er || illegal_op !== eill ||
                rd_addr_out !== rd || regwrite_out !== (rw && !eill)) begin
                miscompares++;
                $display("FAIL random[%0d] op=%0d a=%h b=%h: got res=%h lat=%0d ill=%b rd=%0d rw=%b required res=%h lat=%0d ill=%b rd=%0d rw=%b",
                         i, c, a, b, result, lat, illegal_op, rd_addr_out, regwrite_out,
                         er, ref_latency(c, b), eill, rd, rw && !eill);
            end
            retire();
        end
    endtask

    task automatic test_backpressure();
        int lat;
        logic [XLEN-1:0] r0;
        start_op(4'd2, 32'd100, 32'd23, 5'd17, 1'b1);
        wait_result(lat);
        r0 = result;
        for (int k = 0; k < 5; k++) begin
            if (k == 2) begin
                alu_control = 4'd7; op_a = 32'h5; op_b = 32'h3; rd_addr = 5'd3; in_valid = 1'b1;
            end
            vectors++;
            if (!out_valid || in_ready || r0 !== 32'd123 || result !== r0 || rd_addr_out !== 5'd17 || regwrite_out !== 1'b1) begin
                miscompares++;
                $display("FAIL backpressure[%0d]: got valid=%b rdy=%b res=%h rd=%0d rw=%b required 1 0 %h 17 1",
                         k, out_valid, in_ready, result, rd_addr_out, regwrite_out, 32'd123);
            end
            @(posedge clk); #1;
            in_valid = 1'b0;
        end
        retire();
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL bp_no_queue[%0d]: got valid=%b rdy=%b required 0 1", k, out_valid, in_ready);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid_shift();
        int lat;
        bit seen;
        start_op(4'd5, 32'hFFFF0000, 32'd20, 5'd12, 1'b1);
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        vectors++;
        if ({out_valid, in_ready, result, rd_addr_out, regwrite_out, illegal_op} !== {1'b0, 1'b1, 32'h0, 5'd0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL shift_abort: got valid=%b rdy=%b res=%h rd=%0d rw=%b ill=%b required 0 1 0 0 0 0",
                     out_valid, in_ready, result, rd_addr_out, regwrite_out, illegal_op);
        end
        seen = 0;
        repeat (15) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1;
        end
        vectors++;
        if (seen) begin
            miscompares++;
            $display("FAIL shift_abort_no_result: got out_valid=1 required 0");
        end
        start_op(4'd3, 32'h3, 32'd4, 5'd2, 1'b1);
        wait_result(lat);
        vectors++;
        if (lat !== 5 || result !== 32'h30 || rd_addr_out !== 5'd2) begin
            miscompares++;
            $display("FAIL after_abort: got res=%h lat=%0d rd=%0d required 00000030 5 2", result, lat, rd_addr_out);
        end
        retire();
    endtask

    // Continuous in_valid and out_ready: accepts must land every second edge.
    task automatic test_back_to_back();
        logic [XLEN-1:0] expq[$];
        logic [XLEN-1:0] e;
        int sent, got, last_acc, cyc;
        bit acc;
        sent = 0; got = 0; last_acc = -1;
        alu_control = 4'd2; op_a = $urandom; op_b = $urandom; rd_addr = 5'd1; regwrite_in = 1'b1;
        in_valid = 1'b1; out_ready = 1'b1;
        for (cyc = 0; cyc < 60 && got < 8; cyc++) begin
            acc = in_valid && in_ready;
            if (out_valid) begin
                e = (expq.size() > 0) ? expq.pop_front() : 32'hx;
                got++;
                vectors++;
                if (result !== e) begin
                    miscompares++;
                    $display("FAIL b2b_result[%0d]: got %h required %h", got, result, e);
                end
            end
            if (acc) begin
                expq.push_back(ref_result(alu_control, op_a, op_b));
                if (last_acc >= 0) begin
                    vectors++;
                    if (cyc - last_acc != 2) begin
                        miscompares++;
                        $display("FAIL b2b_interval: got %0d required 2", cyc - last_acc);
                    end
                end
                last_acc = cyc;
                sent++;
            end
            @(posedge clk); #1;
            if (acc) begin
                alu_control = 4'($urandom_range(0, 9));
                if (alu_control == 4'd3 || alu_control == 4'd5 || alu_control == 4'd9) alu_control = 4'd4;
                op_a = $urandom; op_b = $urandom;
                if (sent == 8) in_valid = 1'b0;
            end
        end
        in_valid = 1'b0; out_ready = 1'b0;
        vectors++;
        if (got != 8) begin
            miscompares++;
            $display("FAIL b2b_count: got %0d results required 8", got);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_illegal();
        test_backpressure();
        test_reset_mid_shift();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
